sg_0001: RTL and testbench

SG_0001 -- requirements
Module: sg_0001

---
 rtl/sd_pkg.sv | 18 +
 rtl/sg_shift.sv | 48 ++++
 rtl/sg_0001.sv | 138 +++++++++++++
 tb/tb_sg_0001.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the serial frame generator and its sequence detector.
package sd_pkg;

    // Frame phases, shared with the detector so both sides agree on the framing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } sg_state_e;

    // Sync pattern, sent MSB first: 0,0,0,1.
    localparam logic [3:0] SYNC_PAT = 4'b0001;

    // Width of the zero-run counter; bit stuffing caps a run at two zeros.
    localparam int ZRUN_W = 2;

endpackage

// File: rtl/sg_shift.sv
// Payload shift register and sent-bit counter for the frame generator.
// A hold cycle keeps the current MSB in place while a stuff bit goes out.
module sg_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              hold,
    output logic              bit_o,
    output logic              done_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next state: load a fresh word or shift one payload bit out; hold freezes both.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = '0;
        end else if (shift_en && !hold) begin
            sr_d  = {sr_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // MSB is the next payload bit to send; done means every payload bit has been sent.
    assign bit_o  = sr_q[DATA_W-1];
    assign done_o = (cnt_q == CNT_W'(DATA_W));

endmodule

// File: rtl/sg_0001.sv
// Serial frame generator: idle-high line, 0001 sync, MSB-first payload with a
// stuffed 1 after every two consecutive payload zeros, then an idle-high gap.
// All outputs except din_ready are registered; the state names the bit on y.
module sg_0001
    import sd_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              y,
    output logic              busy,
    output logic              frame_done
);
    sg_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;      // sync index in SYNC, gap index in GAP
    logic [ZRUN_W-1:0] zrun_q, zrun_d, zrun_nx;
    logic              y_q, y_d;
    logic              busy_q, busy_d;
    logic              fd_q, fd_d;

    logic sh_load, sh_shift, sh_hold, sh_bit, sh_done;

    sg_shift #(.DATA_W(DATA_W)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (din),
        .shift_en  (sh_shift),
        .hold      (sh_hold),
        .bit_o     (sh_bit),
        .done_o    (sh_done)
    );

    assign din_ready  = (state_q == IDLE) && !rst;
    assign y          = y_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;

    // Next-state logic: decide the bit that goes on y in the coming cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        busy_d   = busy_q;
        fd_d     = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_hold  = 1'b0;
        // Zero run including the bit currently on y.
        zrun_nx  = y_q ? '0 : zrun_q + 1'b1;
        zrun_d   = zrun_q;
        case (state_q)
            IDLE: begin
                y_d    = 1'b1;
                busy_d = 1'b0;
                if (din_valid && din_ready) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    zrun_d  = '0;
                    y_d     = SYNC_PAT[3];
                    busy_d  = 1'b1;
                    sh_load = 1'b1;
                end
            end
            SYNC: begin
                if (cnt_q == 4'd3) begin
                    // Sync's trailing 1 ends any run; payload starts with a clean count.
                    state_d  = DATA;
                    cnt_d    = '0;
                    zrun_d   = '0;
                    y_d      = sh_bit;
                    sh_shift = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    y_d   = SYNC_PAT[2'd2 - cnt_q[1:0]];
                end
            end
            DATA: begin
                zrun_d = zrun_nx;
                if (sh_done) begin
                    // Last payload bit is on y: never stuff here, go straight to gap.
                    state_d = GAP;
                    cnt_d   = '0;
                    zrun_d  = '0;
                    y_d     = 1'b1;
                    fd_d    = 1'b1;
                end else if (zrun_nx == ZRUN_W'(2)) begin
                    y_d      = 1'b1;
                    sh_shift = 1'b1;
                    sh_hold  = 1'b1;
                end else begin
                    y_d      = sh_bit;
                    sh_shift = 1'b1;
                end
            end
            GAP: begin
                y_d = 1'b1;
                if (cnt_q == 4'(GAP_BITS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and registered outputs; reset aborts any frame and idles the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zrun_q  <= '0;
            y_q     <= 1'b1;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zrun_q  <= zrun_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

endmodule

// File: tb/tb_sg_0001.sv
// Scoreboard bench for sg_0001: stimulus pushes the expected per-cycle line
// waveform of each accepted frame; a monitor pops one entry per busy cycle.
module tb_sg_0001;
    localparam int DW = 8;
    localparam int GB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          din_ready;
    logic          y;
    logic          busy;
    logic          frame_done;

    sg_0001 #(.DATA_W(DW), .GAP_BITS(GB)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .y          (y),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit y;
        bit fd;
        bit sync;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   frames = 0;
    int   det_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit yy, input bit fd, input bit sy);
        exp_t e;
        e.y = yy; e.fd = fd; e.sync = sy;
        return e;
    endfunction

    // Reference: the line waveform of one frame, built from the framing rules.
    task automatic push_frame(input logic [DW-1:0] d);
        int zeros = 0;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1));
        for (int i = DW - 1; i >= 0; i--) begin
            exp_q.push_back(mk(d[i], 1'b0, 1'b0));
            zeros = d[i] ? 0 : zeros + 1;
            if (zeros == 2 && i > 0) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
                zeros = 0;
            end
        end
        for (int g = 0; g < GB; g++)
            exp_q.push_back(mk(1'b1, g == 0, 1'b0));
    endtask

    // mode 0: valid low between frames; 1: valid held high; 2: junk while busy.
    task automatic send(input logic [DW-1:0] d, input int mode);
        int  n = 0;
        bit  got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (din_ready) begin
                din       = d;
                din_valid = 1'b1;
                got       = 1;
            end else begin
                n++;
                if (mode == 2) begin
                    din       = DW'($urandom);
                    din_valid = 1'($urandom_range(0, 1));
                end else if (mode == 0) begin
                    din_valid = 1'b0;
                end
            end
        end
        if (!got) begin
            chk("ready_timeout", 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        push_frame(d);
        frames++;
        #1;
        if (mode == 0) din_valid = 1'b0;
        if (mode == 2) begin
            din       = DW'($urandom);
            din_valid = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
    endtask

    // Monitor: one expected entry per busy cycle, idle-line checks otherwise.
    // hist holds the last four line bits to spot the 0001 sync as a detector would.
    initial begin : monitor
        logic [3:0] hist = 4'b1111;
        bit         det;
        exp_t       e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            hist = {hist[2:0], y};
            det  = (hist == 4'b0001);
            if (det) det_cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy", 32'(busy), 32'd1);
                chk("y", 32'(y), 32'(e.y));
                chk("frame_done", 32'(frame_done), 32'(e.fd));
                chk("sync_detect", 32'(det), 32'(e.sync));
                chk("din_ready_busy", 32'(din_ready), 32'd0);
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_y", 32'(y), 32'd1);
                chk("idle_frame_done", 32'(frame_done), 32'd0);
                chk("idle_detect", 32'(det), 32'd0);
                chk("idle_din_ready", 32'(din_ready), 32'(!rst));
            end
        end
    end

    initial begin : stim
        int d0, f0;
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Directed frames: all ones, all zeros (maximal stuffing), mixed.
        send(8'hFF, 0);
        drain();
        send(8'h00, 0);
        drain();
        send(8'hA5, 0);
        drain();
        // Boundary: two trailing zeros must not be stuffed.
        send(8'h24, 0);
        drain();

        // Reset in c7 of a frame: abort, idle line, no resumption.
        send(8'h00, 0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);

        // Back-to-back random frames with valid held high; one sync per frame.
        d0 = det_cnt;
        f0 = frames;
        for (int i = 0; i < 100; i++) send(DW'($urandom), 1);
        @(negedge clk) din_valid = 1'b0;
        drain();
        chk("det_per_frame", 32'(det_cnt - d0), 32'(frames - f0));

        // Input activity while busy must not disturb the waveform.
        for (int i = 0; i < 30; i++) send(DW'($urandom), 2);
        @(negedge clk) din_valid = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $finish;
    end

endmodule
